brq_ifetch_port_arbiter: RTL and testbench

Two-requester arbiter that shares one instruction-memory port between the IFU prefetch buffer (port 0) and an auxiliary fetch requester (port 1), e.g. a debug program-buffer or boot loader. It sits between the fetch unit and the instruction memory/cache. Arbitration is round-robin with an address lock. An in-order ID FIFO routes each response back to the requester that issued it.

---
 rtl/brq_ifetch_port_arbiter.sv | 108 ++++++++++
 tb/tb_brq_ifetch_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_ifetch_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the IFU (port 0)
// and an auxiliary fetch requester (port 1); an in-order ID FIFO routes responses back.
module brq_ifetch_port_arbiter #(
   parameter  int unsigned MaxOutstanding = 2,
   localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [31:0]     if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [31:0]     if_rdata_o,
   output logic            if_err_o,
   input  logic            ax_req_i,
   input  logic [31:0]     ax_addr_i,
   output logic            ax_gnt_o,
   output logic            ax_rvalid_o,
   output logic [31:0]     ax_rdata_o,
   output logic            ax_err_o,
   output logic            mem_req_o,
   output logic [31:0]     mem_addr_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [31:0]     mem_rdata_i,
   input  logic            mem_err_i,
   output logic [CntW-1:0] outstanding_o,
   output logic            busy_o,
   output logic            unexp_rvalid_o
);

   localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic        SelIf = 1'b0;
   localparam logic        SelAx = 1'b1;

   logic [CntW-1:0]           count_q;
   logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [MaxOutstanding-1:0] id_q;
   logic                      lock_q, lock_sel_q, last_q, unexp_q;
   logic                      sel, sel_req, can_issue, req, hs;
   logic                      fifo_empty, pop, head;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // A stalled request keeps its owner selected so the memory address cannot change.
   always_comb begin
      sel = SelIf;
      if (lock_q)                     sel = lock_sel_q;
      else if (if_req_i && ax_req_i)  sel = ~last_q;
      else if (ax_req_i)              sel = SelAx;
   end

   assign sel_req    = (sel == SelAx) ? ax_req_i : if_req_i;
   assign can_issue  = count_q < CntW'(MaxOutstanding);
   assign req        = ~rst_i & can_issue & sel_req;
   assign hs         = req & mem_gnt_i;
   assign fifo_empty = (count_q == '0);
   assign pop        = ~rst_i & mem_rvalid_i & ~fifo_empty;
   assign head       = id_q[rd_ptr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         id_q       <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= SelIf;
         last_q     <= SelAx;
         unexp_q    <= 1'b0;
      end else begin
         if (hs) begin
            id_q[wr_ptr_q] <= sel;
            wr_ptr_q       <= ptr_inc(wr_ptr_q);
            last_q         <= sel;
            lock_q         <= 1'b0;
         end else if (req && !mem_gnt_i) begin
            lock_q     <= 1'b1;
            lock_sel_q <= sel;
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (mem_rvalid_i && fifo_empty) unexp_q <= 1'b1;
         // Pop never frees a slot for a same-cycle grant; can_issue uses the registered count.
         case ({hs, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign mem_req_o      = req;
   assign mem_addr_o     = rst_i ? '0 : ((sel == SelAx) ? ax_addr_i : if_addr_i);
   assign if_gnt_o       = hs & (sel == SelIf);
   assign ax_gnt_o       = hs & (sel == SelAx);
   assign if_rvalid_o    = pop & (head == SelIf);
   assign ax_rvalid_o    = pop & (head == SelAx);
   assign if_err_o       = if_rvalid_o & mem_err_i;
   assign ax_err_o       = ax_rvalid_o & mem_err_i;
   assign if_rdata_o     = rst_i ? '0 : mem_rdata_i;
   assign ax_rdata_o     = rst_i ? '0 : mem_rdata_i;
   assign outstanding_o  = count_q;
   assign busy_o         = ~fifo_empty | req;
   assign unexp_rvalid_o = unexp_q;

endmodule

// File: tb/tb_brq_ifetch_port_arbiter.sv
// Bench for brq_ifetch_port_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_brq_ifetch_port_arbiter;

   logic        clk = 0, rst = 0;
   logic        if_req = 0, ax_req = 0, mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
   logic [31:0] if_addr = 0, ax_addr = 0, mem_rdata = 0;

   logic        a_if_gnt, a_if_rvalid, a_if_err, a_ax_gnt, a_ax_rvalid, a_ax_err;
   logic        a_mem_req, a_busy, a_unexp;
   logic [31:0] a_if_rdata, a_ax_rdata, a_mem_addr;
   logic [1:0]  a_out;
   logic        b_if_gnt, b_if_rvalid, b_if_err, b_ax_gnt, b_ax_rvalid, b_ax_err;
   logic        b_mem_req, b_busy, b_unexp;
   logic [31:0] b_if_rdata, b_ax_rdata, b_mem_addr;
   logic [2:0]  b_out;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   brq_ifetch_port_arbiter #(.MaxOutstanding(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt), .if_rvalid_o(a_if_rvalid),
      .if_rdata_o(a_if_rdata), .if_err_o(a_if_err),
      .ax_req_i(ax_req), .ax_addr_i(ax_addr), .ax_gnt_o(a_ax_gnt), .ax_rvalid_o(a_ax_rvalid),
      .ax_rdata_o(a_ax_rdata), .ax_err_o(a_ax_err),
      .mem_req_o(a_mem_req), .mem_addr_o(a_mem_addr), .mem_gnt_i(mem_gnt),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(a_out), .busy_o(a_busy), .unexp_rvalid_o(a_unexp));

   brq_ifetch_port_arbiter #(.MaxOutstanding(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rvalid),
      .if_rdata_o(b_if_rdata), .if_err_o(b_if_err),
      .ax_req_i(ax_req), .ax_addr_i(ax_addr), .ax_gnt_o(b_ax_gnt), .ax_rvalid_o(b_ax_rvalid),
      .ax_rdata_o(b_ax_rdata), .ax_err_o(b_ax_err),
      .mem_req_o(b_mem_req), .mem_addr_o(b_mem_addr), .mem_gnt_i(mem_gnt),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(b_out), .busy_o(b_busy), .unexp_rvalid_o(b_unexp));

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      if_req = 0; ax_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
      if_addr = 0; ax_addr = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1; if_req = 1; ax_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hdead_beef;
      if_addr = 32'h1234_5678;
      #2;
      total++;
      if ({a_mem_req, a_if_gnt, a_ax_gnt, a_if_rvalid, a_ax_rvalid, a_busy, a_unexp} !== 7'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0000000",
            {a_mem_req, a_if_gnt, a_ax_gnt, a_if_rvalid, a_ax_rvalid, a_busy, a_unexp});
      end
      total++;
      if (a_out !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", a_out); end
      total++;
      if ({a_mem_addr, a_if_rdata} !== 64'd0) begin
         bad++; $display("FAIL reset_data: got %h %h want 0", a_mem_addr, a_if_rdata);
      end
      do_reset();
   endtask

   task automatic test_single_ifu();
      do_reset();
      if_req = 1; if_addr = 32'h8000_0000; mem_gnt = 1;
      @(negedge clk);
      total++;
      if ({a_mem_req, a_if_gnt, a_ax_gnt} !== 3'b110 || a_mem_addr !== 32'h8000_0000) begin
         bad++; $display("FAIL t1_grant: got req/ig/ag=%b addr=%h want 110 80000000",
            {a_mem_req, a_if_gnt, a_ax_gnt}, a_mem_addr);
      end
      cyc(); if_req = 0; mem_gnt = 0;
      total++;
      if (a_out !== 2'd1) begin bad++; $display("FAIL t1_count1: got %0d want 1", a_out); end
      cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0013;
      @(negedge clk);
      total++;
      if (a_if_rvalid !== 1'b1 || a_ax_rvalid !== 1'b0 || a_if_rdata !== 32'h13) begin
         bad++; $display("FAIL t1_rsp: got irv=%b arv=%b data=%h want 1 0 00000013",
            a_if_rvalid, a_ax_rvalid, a_if_rdata);
      end
      cyc(); mem_rvalid = 0;
      total++;
      if (a_out !== 2'd0) begin bad++; $display("FAIL t1_count0: got %0d want 0", a_out); end
   endtask

   task automatic test_tie_rr();
      do_reset();
      if_req = 1; ax_req = 1; if_addr = 32'h1000; ax_addr = 32'h2000; mem_gnt = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (b_if_gnt !== (i % 2 == 0) || b_ax_gnt !== (i % 2 == 1) ||
             b_mem_addr !== ((i % 2 == 0) ? 32'h1000 : 32'h2000)) begin
            bad++; $display("FAIL t2_gnt%0d: got ig=%b ag=%b addr=%h", i, b_if_gnt, b_ax_gnt, b_mem_addr);
         end
         cyc();
      end
      if_req = 0; ax_req = 0; mem_gnt = 0;
      total++;
      if (b_out !== 3'd4) begin bad++; $display("FAIL t2_count4: got %0d want 4", b_out); end
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1; mem_rdata = i;
         @(negedge clk);
         total++;
         if (b_if_rvalid !== (i % 2 == 0) || b_ax_rvalid !== (i % 2 == 1)) begin
            bad++; $display("FAIL t2_rsp%0d: got irv=%b arv=%b", i, b_if_rvalid, b_ax_rvalid);
         end
         cyc();
      end
      mem_rvalid = 0;
      total++;
      if (b_out !== 3'd0) begin bad++; $display("FAIL t2_count0: got %0d want 0", b_out); end
   endtask

   task automatic test_lock();
      do_reset();
      // IFU handshake first so an unlocked tie would go to AX
      if_req = 1; if_addr = 32'h50; mem_gnt = 1;
      cyc(); if_req = 0; mem_gnt = 0; mem_rvalid = 1;
      cyc(); mem_rvalid = 0;
      if_req = 1; if_addr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin ax_req = 1; ax_addr = 32'h200; end
         @(negedge clk);
         total++;
         if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h100 || a_ax_gnt !== 1'b0 || a_if_gnt !== 1'b0) begin
            bad++; $display("FAIL t3_hold%0d: got req=%b addr=%h ag=%b ig=%b want 1 100 0 0",
               i, a_mem_req, a_mem_addr, a_ax_gnt, a_if_gnt);
         end
         cyc();
      end
      mem_gnt = 1;
      @(negedge clk);
      total++;
      if (a_if_gnt !== 1'b1 || a_ax_gnt !== 1'b0 || a_mem_addr !== 32'h100) begin
         bad++; $display("FAIL t3_ifgnt: got ig=%b ag=%b addr=%h", a_if_gnt, a_ax_gnt, a_mem_addr);
      end
      cyc(); if_req = 0;
      @(negedge clk);
      total++;
      if (a_ax_gnt !== 1'b1 || a_mem_addr !== 32'h200) begin
         bad++; $display("FAIL t3_axgnt: got ag=%b addr=%h want 1 200", a_ax_gnt, a_mem_addr);
      end
      cyc(); ax_req = 0; mem_gnt = 0;
      mem_rvalid = 1; cyc(); cyc(); mem_rvalid = 0;
   endtask

   task automatic test_full();
      do_reset();
      if_req = 1; mem_gnt = 1;
      for (int i = 0; i < 2; i++) begin
         if_addr = 32'h40 + 4 * i;
         @(negedge clk);
         total++;
         if (a_if_gnt !== 1'b1) begin bad++; $display("FAIL t4_gnt%0d: got %b want 1", i, a_if_gnt); end
         cyc();
      end
      if_addr = 32'h48; mem_rvalid = 1; mem_rdata = 32'h99;
      @(negedge clk);
      total++;
      if ({a_mem_req, a_busy, a_if_gnt, a_if_rvalid} !== 4'b0101) begin
         bad++; $display("FAIL t4_full: got req/busy/ig/irv=%b want 0101",
            {a_mem_req, a_busy, a_if_gnt, a_if_rvalid});
      end
      cyc(); mem_rvalid = 0;
      @(negedge clk);
      total++;
      if (a_out !== 2'd1 || a_mem_req !== 1'b1 || a_if_gnt !== 1'b1) begin
         bad++; $display("FAIL t4_regrant: got cnt=%0d req=%b ig=%b want 1 1 1", a_out, a_mem_req, a_if_gnt);
      end
      cyc(); if_req = 0; mem_gnt = 0;
      total++;
      if (a_out !== 2'd2) begin bad++; $display("FAIL t4_count2: got %0d want 2", a_out); end
      mem_rvalid = 1; cyc(); cyc(); mem_rvalid = 0;
   endtask

   task automatic test_push_pop();
      do_reset();
      ax_req = 1; ax_addr = 32'h300; mem_gnt = 1;
      cyc(); ax_req = 0;
      if_req = 1; if_addr = 32'h400; mem_rvalid = 1; mem_rdata = 32'haaaa;
      @(negedge clk);
      total++;
      if (a_ax_rvalid !== 1'b1 || a_if_rvalid !== 1'b0 || a_if_gnt !== 1'b1) begin
         bad++; $display("FAIL t5_both: got arv=%b irv=%b ig=%b want 1 0 1", a_ax_rvalid, a_if_rvalid, a_if_gnt);
      end
      cyc(); if_req = 0; mem_gnt = 0; mem_rvalid = 0;
      total++;
      if (a_out !== 2'd1) begin bad++; $display("FAIL t5_count: got %0d want 1", a_out); end
      mem_rvalid = 1; mem_rdata = 32'hbbbb;
      @(negedge clk);
      total++;
      if (a_if_rvalid !== 1'b1 || a_ax_rvalid !== 1'b0) begin
         bad++; $display("FAIL t5_newhead: got irv=%b arv=%b want 1 0", a_if_rvalid, a_ax_rvalid);
      end
      cyc(); mem_rvalid = 0;
   endtask

   task automatic test_unexpected();
      do_reset();
      mem_rvalid = 1; mem_rdata = 32'h77;
      @(negedge clk);
      total++;
      if (a_if_rvalid !== 1'b0 || a_ax_rvalid !== 1'b0) begin
         bad++; $display("FAIL t6_drop: got irv=%b arv=%b want 0 0", a_if_rvalid, a_ax_rvalid);
      end
      cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h500; mem_gnt = 1;
      @(negedge clk);
      total++;
      if (a_unexp !== 1'b1) begin bad++; $display("FAIL t6_sticky: got %b want 1", a_unexp); end
      cyc(); if_req = 0; mem_gnt = 0;
      #3 rst = 1;
      #1;
      total++;
      if (a_unexp !== 1'b0 || a_out !== 2'd0 || a_busy !== 1'b0) begin
         bad++; $display("FAIL t6_async_rst: got unexp=%b cnt=%0d busy=%b want 0 0 0", a_unexp, a_out, a_busy);
      end
      #1 rst = 0;
      cyc(); mem_rvalid = 1;
      @(negedge clk);
      total++;
      if (a_if_rvalid !== 1'b0) begin bad++; $display("FAIL t6_post_rst: got irv=%b want 0", a_if_rvalid); end
      cyc(); mem_rvalid = 0;
      total++;
      if (a_unexp !== 1'b1) begin bad++; $display("FAIL t6_reflag: got %b want 1", a_unexp); end
   endtask

   task automatic test_random();
      bit          q[$];
      bit          last = 1, lk = 0, lks = 0, unx = 0, ireq = 0, areq = 0;
      bit          sel, ereq, popd, hd;
      logic [31:0] ia = 0, aa = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (!ireq) begin ireq = 1'($urandom_range(0, 1)); ia = $urandom; end
         if (!areq) begin areq = 1'($urandom_range(0, 1)); aa = $urandom; end
         if_req = ireq; if_addr = ia; ax_req = areq; ax_addr = aa;
         mem_gnt    = ($urandom_range(0, 2) != 0);
         mem_rvalid = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
         mem_rdata  = $urandom; mem_err = 1'($urandom_range(0, 1));
         if (lk)                sel = lks;
         else if (ireq && areq) sel = !last;
         else                   sel = areq;
         ereq = (q.size() < 2) && (sel ? areq : ireq);
         popd = mem_rvalid && (q.size() > 0);
         hd   = popd ? q[0] : 1'b0;
         @(negedge clk);
         total++;
         if (a_mem_req !== ereq || (ereq && a_mem_addr !== (sel ? aa : ia))) begin
            bad++; $display("FAIL rnd_req c%0d: got req=%b addr=%h want %b %h", c, a_mem_req, a_mem_addr,
               ereq, sel ? aa : ia);
         end
         total++;
         if (a_if_gnt !== (ereq && mem_gnt && !sel) || a_ax_gnt !== (ereq && mem_gnt && sel)) begin
            bad++; $display("FAIL rnd_gnt c%0d: got ig=%b ag=%b", c, a_if_gnt, a_ax_gnt);
         end
         total++;
         if (a_if_rvalid !== (popd && !hd) || a_ax_rvalid !== (popd && hd) ||
             a_if_err !== (popd && !hd && mem_err) || a_ax_err !== (popd && hd && mem_err) ||
             a_if_rdata !== mem_rdata || a_ax_rdata !== mem_rdata) begin
            bad++; $display("FAIL rnd_rsp c%0d: got irv=%b arv=%b ie=%b ae=%b want %b %b", c,
               a_if_rvalid, a_ax_rvalid, a_if_err, a_ax_err, popd && !hd, popd && hd);
         end
         total++;
         if (a_out !== 2'(q.size()) || a_busy !== (q.size() > 0 || ereq) || a_unexp !== unx) begin
            bad++; $display("FAIL rnd_state c%0d: got cnt=%0d busy=%b unexp=%b want %0d %b %b", c,
               a_out, a_busy, a_unexp, q.size(), q.size() > 0 || ereq, unx);
         end
         @(posedge clk);
         if (mem_rvalid && q.size() == 0) unx = 1;
         if (popd) void'(q.pop_front());
         if (ereq && mem_gnt) begin
            q.push_back(sel); last = sel; lk = 0;
            if (sel) areq = 0; else ireq = 0;
         end else if (ereq) begin
            lk = 1; lks = sel;
         end
         #1;
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_ifu();
      test_tie_rr();
      test_lock();
      test_full();
      test_push_pop();
      test_unexpected();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
